hpu_soft_reset_responder: RTL

Processing-clock-domain responder for the HPU soft reset. It receives the soft-reset request level from the configuration domain, already synchronized into the prc domain. It asks the datapath to quiesce, then asserts a bank of staged processing resets. When the request is withdrawn, it releases those resets one stage at a time. Its acknowledge level (low while in reset, high when fully released) is synchronized back to the configuration-side initiator, which uses it to complete its ASSERT/DEASSERT handshake.

---
 rtl/hpu_soft_reset_pkg.sv | 23 ++
 rtl/hpu_soft_reset_filter.sv | 50 +++++
 rtl/hpu_soft_reset_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hpu_soft_reset_pkg.sv
// ============================================================================
// hpu_soft_reset_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the HPU soft-reset responder slice.
//   state_t    : responder FSM states (IDLE, QUIESCE, ASSERT, RELEASE).
//   cnt_width  : width of a counter that must hold values 0..max_val.
//                Never returns less than 1, so a parameter of 0 still
//                yields a legal (unused) one-bit counter.
// ============================================================================
package hpu_soft_reset_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        ASSERT  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    function automatic int cnt_width(input int max_val);
        return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hpu_soft_reset_filter.sv
// ============================================================================
// hpu_soft_reset_filter
// ----------------------------------------------------------------------------
// Level stability filter. The output follows the input only after the input
// has held the opposite level for FILTER_CYCLES consecutive clock cycles.
// A shorter excursion restarts the count.
//
// Parameters:
//   FILTER_CYCLES : consecutive cycles required before a new level is taken
//                   (>= 1).
// Ports:
//   clk  : in  clock
//   rst  : in  asynchronous active-high reset (output and count go to 0)
//   din  : in  raw level, already synchronous to clk
//   dout : out accepted (filtered) level, registered
// ============================================================================
module hpu_soft_reset_filter
    import hpu_soft_reset_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int            CW   = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt;

    // The count tracks how many consecutive samples have disagreed with the
    // accepted level. The sample that brings it to FILTER_CYCLES flips the
    // output on that same edge, so the count never exceeds LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= 1'b0;
            cnt  <= '0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt >= LAST) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hpu_soft_reset_responder.sv
// ============================================================================
// hpu_soft_reset_responder
// ----------------------------------------------------------------------------
// Processing-domain responder for the HPU soft reset. A filtered soft-reset
// request first asks the datapath to quiesce, then asserts a bank of staged
// resets for at least HOLD_CYCLES. Once the request is withdrawn the stages
// are released one by one, RELEASE_GAP cycles apart, and finally reset_ack
// rises to tell the configuration-side initiator that the reset is complete.
// Power-on (prc_arst) behaves like a soft reset that is already in ASSERT.
//
// Parameters:
//   NB_STAGE        : number of staged reset outputs (released in index order)
//   FILTER_CYCLES   : request stability filter length (>= 1)
//   HOLD_CYCLES     : minimum cycles all stages stay asserted (>= 1)
//   RELEASE_GAP     : cycles between stage releases and before ack (>= 1)
//   QUIESCE_TIMEOUT : max cycles to wait for quiesce_ack, 0 = no wait
// Ports:
//   prc_clk         : in  processing clock
//   prc_arst        : in  asynchronous active-high reset
//   soft_srst_n     : in  soft-reset request, active-low, synchronous
//   quiesce_ack     : in  datapath idle indication
//   quiesce_req     : out ask the datapath to drain
//   stage_srst_n    : out staged resets, active-low
//   reset_ack       : out 0 = in reset, 1 = fully released
//   busy            : out FSM is not IDLE
//   quiesce_timeout : out sticky flag, quiesce wait expired without ack
// ============================================================================
module hpu_soft_reset_responder
    import hpu_soft_reset_pkg::*;
#(
    parameter int NB_STAGE        = 4,
    parameter int FILTER_CYCLES   = 4,
    parameter int HOLD_CYCLES     = 16,
    parameter int RELEASE_GAP     = 8,
    parameter int QUIESCE_TIMEOUT = 64
) (
    input  logic                prc_clk,
    input  logic                prc_arst,
    input  logic                soft_srst_n,
    input  logic                quiesce_ack,
    output logic                quiesce_req,
    output logic [NB_STAGE-1:0] stage_srst_n,
    output logic                reset_ack,
    output logic                busy,
    output logic                quiesce_timeout
);

    localparam int H_W = cnt_width(HOLD_CYCLES);
    localparam int G_W = cnt_width(RELEASE_GAP);
    localparam int Q_W = cnt_width(QUIESCE_TIMEOUT);

    // Counters are loaded with (length - 1) on the edge that enters the
    // state, so that a state lasting N cycles exits on the N-th edge.
    localparam logic [H_W-1:0] HOLD_LOAD = H_W'(HOLD_CYCLES - 1);
    localparam logic [G_W-1:0] GAP_LOAD  = G_W'(RELEASE_GAP - 1);
    localparam logic [Q_W-1:0] Q_LOAD    =
        (QUIESCE_TIMEOUT > 0) ? Q_W'(QUIESCE_TIMEOUT - 1) : '0;

    localparam logic [NB_STAGE-1:0] STAGE_ONE = NB_STAGE'(1);

    state_t         state;
    logic [H_W-1:0] hold_cnt;
    logic [G_W-1:0] gap_cnt;
    logic [Q_W-1:0] q_cnt;
    logic           req_raw;
    logic           filt_req;

    // The request arrives active-low; the filter works on the active-high
    // form so that its reset value of 0 means "no request".
    assign req_raw = ~soft_srst_n;

    hpu_soft_reset_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk  (prc_clk),
        .rst  (prc_arst),
        .din  (req_raw),
        .dout (filt_req)
    );

    // Responder FSM with all outputs registered alongside the state.
    // Reset lands directly in ASSERT with the hold counter loaded, so that
    // power-on runs the same hold-then-staged-release sequence as a soft
    // reset. Stages form a thermometer code: releasing the next stage is a
    // shift-in of a 1, and the sequence is finished when all bits are 1.
    // A request that returns during RELEASE re-asserts every stage at once
    // and restarts the whole sequence from the quiesce step.
    always_ff @(posedge prc_clk or posedge prc_arst) begin
        if (prc_arst) begin
            state           <= ASSERT;
            hold_cnt        <= HOLD_LOAD;
            gap_cnt         <= '0;
            q_cnt           <= '0;
            stage_srst_n    <= '0;
            reset_ack       <= 1'b0;
            quiesce_req     <= 1'b0;
            busy            <= 1'b1;
            quiesce_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (filt_req) begin
                        busy            <= 1'b1;
                        quiesce_timeout <= 1'b0;
                        if (QUIESCE_TIMEOUT == 0) begin
                            state        <= ASSERT;
                            hold_cnt     <= HOLD_LOAD;
                            stage_srst_n <= '0;
                            reset_ack    <= 1'b0;
                            quiesce_req  <= 1'b0;
                        end else begin
                            state       <= QUIESCE;
                            q_cnt       <= Q_LOAD;
                            quiesce_req <= 1'b1;
                        end
                    end
                end

                QUIESCE: begin
                    // An acknowledge wins over an expiring timeout on the
                    // same edge; the flag only reports a genuine miss.
                    if (quiesce_ack) begin
                        state        <= ASSERT;
                        hold_cnt     <= HOLD_LOAD;
                        stage_srst_n <= '0;
                        reset_ack    <= 1'b0;
                        quiesce_req  <= 1'b0;
                    end else if (q_cnt == '0) begin
                        state           <= ASSERT;
                        hold_cnt        <= HOLD_LOAD;
                        stage_srst_n    <= '0;
                        reset_ack       <= 1'b0;
                        quiesce_req     <= 1'b0;
                        quiesce_timeout <= 1'b1;
                    end else begin
                        q_cnt <= q_cnt - 1'b1;
                    end
                end

                ASSERT: begin
                    // The hold keeps running while the request is still
                    // present, so a long request simply extends ASSERT.
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end else if (!filt_req) begin
                        state        <= RELEASE;
                        stage_srst_n <= STAGE_ONE;
                        gap_cnt      <= GAP_LOAD;
                    end
                end

                RELEASE: begin
                    if (filt_req) begin
                        stage_srst_n    <= '0;
                        reset_ack       <= 1'b0;
                        quiesce_timeout <= 1'b0;
                        gap_cnt         <= GAP_LOAD;
                        hold_cnt        <= HOLD_LOAD;
                        if (QUIESCE_TIMEOUT == 0) begin
                            state       <= ASSERT;
                            quiesce_req <= 1'b0;
                        end else begin
                            state       <= QUIESCE;
                            q_cnt       <= Q_LOAD;
                            quiesce_req <= 1'b1;
                        end
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (&stage_srst_n) begin
                        state     <= IDLE;
                        reset_ack <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        stage_srst_n <= (stage_srst_n << 1) | STAGE_ONE;
                        gap_cnt      <= GAP_LOAD;
                    end
                end

                default: begin
                    state <= state_t'('x);
                end
            endcase
        end
    end

endmodule
